// File: rtl/traffic_phase_controller.sv
// Two-direction intersection sequencer: green/yellow/all-red phases paced by a tick strobe,
// with a 0..5 countdown for the 7-segment display and a pedestrian request that cuts green short.
module traffic_phase_controller #(
  parameter int unsigned GREEN_TIME  = 5,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned RED_TIME    = 1,
  parameter int unsigned PED_CUT     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [3:0] count,
  output logic [2:0] phase,
  output logic       ped_wait
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] GREEN_C  = CW'(GREEN_TIME);
  localparam logic [CW-1:0] YELLOW_C = CW'(YELLOW_TIME);
  localparam logic [CW-1:0] RED_C    = CW'(RED_TIME);
  localparam logic [CW-1:0] CUT_C    = CW'(PED_CUT);

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5
  } state_e;

  state_e        phase_q, phase_d;
  logic [CW-1:0] count_q, count_d;
  logic          ped_q, ped_d;
  logic [2:0]    ns_q, ns_d;
  logic [2:0]    ew_q, ew_d;

  function automatic logic [CW-1:0] dur_of(input state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   dur_of = GREEN_C;
      NS_YELLOW, EW_YELLOW: dur_of = YELLOW_C;
      default:              dur_of = RED_C;
    endcase
  endfunction

  function automatic state_e next_of(input state_e s);
    case (s)
      RED_B:     next_of = NS_GREEN;
      NS_GREEN:  next_of = NS_YELLOW;
      NS_YELLOW: next_of = RED_A;
      RED_A:     next_of = EW_GREEN;
      EW_GREEN:  next_of = EW_YELLOW;
      default:   next_of = RED_B;
    endcase
  endfunction

  // Next phase, countdown and pedestrian latch
  always_comb begin
    phase_d = phase_q;
    count_d = count_q;
    ped_d   = ped_q | ped_req;

    case (phase_q)
      NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B: begin
        if (tick) begin
          if (count_q == '0) begin
            phase_d = next_of(phase_q);
            count_d = dur_of(phase_d);
            // Entering yellow consumes the request unless a new one arrives now
            if (phase_d == NS_YELLOW || phase_d == EW_YELLOW) begin
              ped_d = ped_req;
            end
          end else if ((phase_q == NS_GREEN || phase_q == EW_GREEN) &&
                       ped_q && (count_q > CUT_C)) begin
            count_d = CUT_C;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end
      default: begin
        phase_d = RED_B;
        count_d = RED_C;
      end
    endcase
  end

  // Lights are decoded from the next phase so they register on the same edge
  always_comb begin
    ns_d = LIGHT_RED;
    ew_d = LIGHT_RED;
    case (phase_d)
      NS_GREEN:  ns_d = LIGHT_GREEN;
      NS_YELLOW: ns_d = LIGHT_YELLOW;
      EW_GREEN:  ew_d = LIGHT_GREEN;
      EW_YELLOW: ew_d = LIGHT_YELLOW;
      default: begin
        ns_d = LIGHT_RED;
        ew_d = LIGHT_RED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= RED_B;
      count_q <= RED_C;
      ped_q   <= 1'b0;
      ns_q    <= LIGHT_RED;
      ew_q    <= LIGHT_RED;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
      ped_q   <= ped_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign count    = count_q;
  assign phase    = phase_q;
  assign ped_wait = ped_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller: directed phase/pedestrian scenarios,
// async mid-run reset and randomized tick/request traffic against a table-driven model.
module tb_traffic_phase_controller;

  localparam int GREEN_T  = 5;
  localparam int YELLOW_T = 2;
  localparam int RED_T    = 1;
  localparam int CUT_T    = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic [3:0] count;
  logic       ped_wait;

  int n_checks = 0;
  int n_fail = 0;

  // Model: phase index 0..5 in ring order, duration and light tables
  int   dur_tab [6] = '{GREEN_T, YELLOW_T, RED_T, GREEN_T, YELLOW_T, RED_T};
  logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int m_ph = 5;
  int m_cnt = RED_T;
  bit m_ped = 1'b0;

  traffic_phase_controller #(
    .GREEN_TIME(GREEN_T), .YELLOW_TIME(YELLOW_T), .RED_TIME(RED_T), .PED_CUT(CUT_T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .count(count),
    .phase(phase), .ped_wait(ped_wait)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ph = 5;
    m_cnt = RED_T;
    m_ped = 1'b0;
  endtask

  task automatic model_clk(input bit tk, input bit pr);
    int nph, ncnt;
    bit nped;
    nph = m_ph;
    ncnt = m_cnt;
    nped = m_ped;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (tk) begin
      if (m_cnt == 0) begin
        nph = (m_ph + 1) % 6;
        ncnt = dur_tab[nph];
        if (nph == 1 || nph == 4) nped = 1'b0;
      end else if ((m_ph == 0 || m_ph == 3) && m_ped && m_cnt > CUT_T) begin
        ncnt = CUT_T;
      end else begin
        ncnt = m_cnt - 1;
      end
    end
    if (pr) nped = 1'b1;
    m_ph = nph;
    m_cnt = ncnt;
    m_ped = nped;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare just after
  task automatic step(input bit tk, input bit pr);
    @(negedge clk);
    tick = tk;
    ped_req = pr;
    @(posedge clk);
    model_clk(tk, pr);
    #1;
    tick = 1'b0;
    ped_req = 1'b0;
    n_checks++;
    if (phase !== 3'(m_ph) || count !== 4'(m_cnt) || ped_wait !== m_ped) begin
      n_fail++;
      $display("FAIL step_state: got phase=%0d count=%0d ped_wait=%0b, want phase=%0d count=%0d ped_wait=%0b",
               phase, count, ped_wait, m_ph, m_cnt, m_ped);
    end
    n_checks++;
    if (ns_light !== ns_tab[m_ph] || ew_light !== ew_tab[m_ph]) begin
      n_fail++;
      $display("FAIL step_lights: got ns=%b ew=%b, want ns=%b ew=%b",
               ns_light, ew_light, ns_tab[m_ph], ew_tab[m_ph]);
    end
    n_checks++;
    if (ns_light !== 3'b100 && ew_light !== 3'b100) begin
      n_fail++;
      $display("FAIL conflict: both heads non-red ns=%b ew=%b", ns_light, ew_light);
    end
  endtask

  task automatic expect_now(input string name, input int ph, input int cnt, input bit pw);
    n_checks++;
    if (phase !== 3'(ph) || count !== 4'(cnt) || ped_wait !== pw) begin
      n_fail++;
      $display("FAIL %s: got phase=%0d count=%0d ped_wait=%0b, want phase=%0d count=%0d ped_wait=%0b",
               name, phase, count, ped_wait, ph, cnt, pw);
    end
  endtask

  task automatic advance_to(input int ph, input int cnt);
    for (int i = 0; i < 60 && !(m_ph == ph && m_cnt == cnt); i++) step(1'b1, 1'b0);
    n_checks++;
    if (m_ph != ph || m_cnt != cnt || phase !== 3'(ph) || count !== 4'(cnt)) begin
      n_fail++;
      $display("FAIL advance_to: got phase=%0d count=%0d, want phase=%0d count=%0d",
               phase, count, ph, cnt);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (phase !== 3'd5 || count !== 4'(RED_T) || ped_wait !== 1'b0 ||
        ns_light !== 3'b100 || ew_light !== 3'b100) begin
      n_fail++;
      $display("FAIL reset: got phase=%0d count=%0d ped=%0b ns=%b ew=%b, want 5 %0d 0 100 100",
               phase, count, ped_wait, ns_light, ew_light, RED_T);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_full_cycle();
    int exp_ph[$];
    int exp_cnt[$];
    for (int c = RED_T - 1; c >= 0; c--) begin exp_ph.push_back(5); exp_cnt.push_back(c); end
    for (int p = 0; p < 5; p++)
      for (int c = dur_tab[p]; c >= 0; c--) begin exp_ph.push_back(p); exp_cnt.push_back(c); end
    exp_ph.push_back(5);
    exp_cnt.push_back(RED_T);
    n_checks++;
    if (exp_ph.size() != 22) begin
      n_fail++;
      $display("FAIL cycle_len: got %0d ticks, want 22", exp_ph.size());
    end
    foreach (exp_ph[i]) begin
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      expect_now("cycle_seq", exp_ph[i], exp_cnt[i], 1'b0);
    end
  endtask

  task automatic test_ped_cut_ns();
    advance_to(0, GREEN_T);
    step(1'b0, 1'b1);
    expect_now("ped_latch", 0, 5, 1'b1);
    step(1'b1, 1'b0);
    expect_now("ped_cut", 0, 2, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    expect_now("ped_cut_tail", 0, 0, 1'b1);
    step(1'b1, 1'b0);
    expect_now("ped_clear_yellow", 1, 2, 1'b0);
  endtask

  task automatic test_ped_during_red();
    advance_to(2, 1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    expect_now("ped_red_hold", 2, 0, 1'b1);
    step(1'b1, 1'b0);
    expect_now("ped_ew_enter", 3, 5, 1'b1);
    step(1'b1, 1'b0);
    expect_now("ped_ew_cut", 3, 2, 1'b1);
    advance_to(3, 0);
    step(1'b1, 1'b0);
    expect_now("ped_ew_clear", 4, 2, 1'b0);
  endtask

  task automatic test_ped_late_green();
    advance_to(0, 1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    expect_now("ped_late_no_cut", 0, 0, 1'b1);
    step(1'b1, 1'b0);
    expect_now("ped_late_clear", 1, 2, 1'b0);
  endtask

  task automatic test_ped_set_wins();
    advance_to(3, 0);
    step(1'b1, 1'b1);
    expect_now("set_wins", 4, 2, 1'b1);
    advance_to(0, GREEN_T);
    expect_now("set_wins_pending", 0, 5, 1'b1);
    step(1'b1, 1'b0);
    expect_now("set_wins_cut", 0, 2, 1'b1);
  endtask

  task automatic test_same_tick_ped();
    advance_to(3, GREEN_T);
    step(1'b1, 1'b1);
    expect_now("same_tick_no_cut", 3, 4, 1'b1);
    step(1'b1, 1'b0);
    expect_now("next_tick_cut", 3, 2, 1'b1);
  endtask

  task automatic test_mid_reset();
    advance_to(3, 3);
    step(1'b0, 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (phase !== 3'd5 || count !== 4'(RED_T) || ped_wait !== 1'b0 ||
        ns_light !== 3'b100 || ew_light !== 3'b100) begin
      n_fail++;
      $display("FAIL async_reset: got phase=%0d count=%0d ped=%0b ns=%b ew=%b",
               phase, count, ped_wait, ns_light, ew_light);
    end
    model_reset();
    for (int i = 0; i < 6; i++) step(i[0], 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    expect_now("resume", 0, GREEN_T, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++)
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 15) == 0));
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_ped_cut_ns();
    test_ped_during_red();
    test_ped_late_green();
    test_ped_set_wins();
    test_same_tick_ped();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
